// File: rtl/spi_word_rx.sv
// SPI mode-0 slave front end: synchronises nCS/SCK/MOSI into clk, assembles
// MSB-first words and queues them in a small first-word-fall-through FIFO.
//
// state    | meaning
// ST_IDLE  | cs_s high or receiver not armed; bit counter held at 0
// ST_SHIFT | cs_s low and armed; each sck_rise shifts in one MOSI bit
module spi_word_rx #(
  parameter int WIDTH       = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             nCS,
  input  logic             SCK,
  input  logic             MOSI,
  output logic [WIDTH-1:0] word_data,
  output logic             word_valid,
  input  logic             word_ready,
  output logic             overflow,
  output logic             frame_err,
  output logic             busy
);

  localparam int CW   = $clog2(WIDTH);
  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic [SYNC_STAGES-1:0] fill_q, fill_d;
  logic                   sck_d_q, sck_d_d;
  logic                   cs_d_q, cs_d_d;
  logic                   armed_q, armed_d;
  logic [WIDTH-2:0]       shift_q, shift_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overflow_q, overflow_d;
  logic [WIDTH-1:0]       mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0]       mem_d [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]        count_q, count_d;

  logic             cs_s, sck_s, mosi_s;
  logic             sck_rise;
  logic [0:0]       rx_state;
  logic [WIDTH-1:0] push_word;
  logic             push, pop, full, push_ok;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sck_s  = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // fill_q marks when cs_s carries a real pin sample rather than the reset
  // preload, so a frame already running at reset release cannot arm us.
  always_comb begin
    cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], nCS};
    sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
    fill_d      = {fill_q[SYNC_STAGES-2:0], 1'b1};
    sck_d_d     = sck_s;
    cs_d_d      = cs_s;
    armed_d     = armed_q | (cs_s & fill_q[SYNC_STAGES-1]);
  end

  assign sck_rise  = sck_s & ~sck_d_q;
  assign rx_state  = (armed_q && !cs_s) ? ST_SHIFT : ST_IDLE;
  assign push_word = {shift_q, mosi_s};

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    push      = 1'b0;
    case (rx_state)
      ST_SHIFT: begin
        if (sck_rise) begin
          shift_d = push_word[WIDTH-2:0];
          if (bit_cnt_q == CW'(WIDTH - 1)) begin
            push      = 1'b1;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + CW'(1);
          end
        end
      end
      default: bit_cnt_d = '0;
    endcase
    frame_err_d = cs_s & ~cs_d_q & (bit_cnt_q != '0);
  end

  assign word_valid = (count_q != '0);
  assign full       = (count_q == CNTW'(FIFO_DEPTH));
  assign pop        = word_valid & word_ready;
  // A push into a full FIFO still lands when the head leaves in the same cycle.
  assign push_ok    = push & (~full | pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_word;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNTW'(1);
      2'b01:   count_d = count_q - CNTW'(1);
      default: count_d = count_q;
    endcase
    overflow_d = overflow_q | (push & full & ~pop);
  end

  always_ff @(posedge clk) begin
    if (!nRST) begin
      cs_sync_q   <= '1;
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      fill_q      <= '0;
      sck_d_q     <= 1'b0;
      cs_d_q      <= 1'b1;
      armed_q     <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      mem_q       <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      cs_sync_q   <= cs_sync_d;
      sck_sync_q  <= sck_sync_d;
      mosi_sync_q <= mosi_sync_d;
      fill_q      <= fill_d;
      sck_d_q     <= sck_d_d;
      cs_d_q      <= cs_d_d;
      armed_q     <= armed_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  assign word_data = word_valid ? mem_q[rd_ptr_q] : '0;
  assign overflow  = overflow_q;
  assign frame_err = frame_err_q;
  assign busy      = armed_q & ~cs_s;

endmodule

// File: tb/tb_spi_word_rx.sv
// Bench for spi_word_rx: drives SPI frames at a 50 ns SCK half-period against a
// 40 ns clk and scores FIFO handshakes against a queue-based reference model.
module tb_spi_word_rx;

  logic        clk;
  logic        nRST;
  logic        nCS;
  logic        SCK;
  logic        MOSI;
  logic [15:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        overflow;
  logic        frame_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int hs_count = 0;
  int fe_cycles = 0;
  int fe_pulses = 0;
  logic fe_prev = 1'b0;

  logic [15:0] model_q[$];
  logic        model_ov = 1'b0;

  spi_word_rx #(.WIDTH(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .nRST       (nRST),
    .nCS        (nCS),
    .SCK        (SCK),
    .MOSI       (MOSI),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference FIFO: a completed frame is accepted while fewer than 4 words wait.
  function automatic void model_push(input logic [15:0] w);
    if (model_q.size() < 4) model_q.push_back(w);
    else model_ov = 1'b1;
  endfunction

  always @(negedge clk) begin
    if (nRST && word_valid && word_ready) begin
      hs_count++;
      if (model_q.size() == 0) chk("spurious_word", 32'(word_data), 32'hffff_ffff);
      else chk("pop_data", 32'(word_data), 32'(model_q.pop_front()));
    end
    if (frame_err) fe_cycles++;
    if (frame_err && !fe_prev) fe_pulses++;
    fe_prev = frame_err;
  end

  task automatic sck_bit(input logic b);
    MOSI = b;
    #50 SCK = 1'b1;
    #50 SCK = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] w, input int n);
    for (int i = 15; i > 15 - n; i--) sck_bit(w[i]);
  endtask

  task automatic send_word(input logic [15:0] w);
    send_bits(w, 16);
    model_push(w);
  endtask

  task automatic cs_low;
    nCS = 1'b0;
    #200;
  endtask

  task automatic cs_high;
    #50 nCS = 1'b1;
    #400;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #5 word_ready = r;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #5 nRST = 1'b0;
    repeat (3) @(posedge clk);
    #5 nRST = 1'b1;
    model_q.delete();
    model_ov = 1'b0;
    #200;
  endtask

  logic [15:0] load_stream [18] = '{
    16'h8003, 16'h8101, 16'h0dc0, 16'h8002, 16'h8020, 16'h0840, 16'h600a, 16'h8001, 16'h01c0,
    16'h4005, 16'h09c0, 16'h8003, 16'h04c0, 16'h0840, 16'h8100, 16'h0dc0, 16'h09c0, 16'h4004};

  initial begin
    int hs0, fe0, fp0, nbits;
    logic [15:0] w;
    logic done;
    nRST = 1'b0; nCS = 1'b1; SCK = 1'b0; MOSI = 1'b0; word_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(word_valid), 0);
    chk("rst_data", 32'(word_data), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #7 nRST = 1'b1;
    #400;

    // Load stream, one burst, consumer always ready
    word_ready = 1'b1;
    hs0 = hs_count; fe0 = fe_cycles;
    cs_low();
    chk("busy_armed", 32'(busy), 1);
    foreach (load_stream[i]) send_word(load_stream[i]);
    cs_high();
    chk("load_hs", hs_count - hs0, 18);
    chk("load_drained", model_q.size(), 0);
    chk("load_overflow", 32'(overflow), 32'(model_ov));
    chk("load_no_fe", fe_cycles - fe0, 0);
    chk("busy_idle", 32'(busy), 0);

    // Backpressure: fifth frame is dropped
    set_ready(1'b0);
    hs0 = hs_count;
    cs_low();
    for (int i = 1; i <= 5; i++) send_word(16'(i * 16'h1111));
    cs_high();
    chk("bp_overflow", 32'(overflow), 32'(model_ov));
    chk("bp_model_ov", 32'(model_ov), 1);
    chk("bp_valid_held", 32'(word_valid), 1);
    set_ready(1'b1);
    #400;
    chk("bp_hs", hs_count - hs0, 4);
    chk("bp_empty", 32'(word_valid), 0);
    chk("bp_sticky", 32'(overflow), 1);
    do_reset();
    chk("ov_cleared", 32'(overflow), 0);

    // Full FIFO with a pop in the same cycle as the fifth push
    set_ready(1'b0);
    hs0 = hs_count;
    cs_low();
    for (int i = 1; i <= 4; i++) send_word(16'(i * 16'h1111));
    send_bits(16'h5555, 15);
    MOSI = 1'b1;
    #50 SCK = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #5 word_ready = 1'b1;
    @(posedge clk);
    #5 word_ready = 1'b0;
    model_push(16'h5555);
    #50 SCK = 1'b0;
    cs_high();
    chk("fp_overflow", 32'(overflow), 32'(model_ov));
    chk("fp_one_pop", hs_count - hs0, 1);
    chk("fp_valid", 32'(word_valid), 1);
    set_ready(1'b1);
    #400;
    chk("fp_hs", hs_count - hs0, 5);
    chk("fp_empty", 32'(word_valid), 0);

    // Partial frames: 7 bits, then a random length
    for (int k = 0; k < 2; k++) begin
      nbits = (k == 0) ? 7 : int'($urandom_range(1, 15));
      hs0 = hs_count; fe0 = fe_cycles; fp0 = fe_pulses;
      cs_low();
      send_bits(16'($urandom), nbits);
      cs_high();
      chk("partial_fe_pulses", fe_pulses - fp0, 1);
      chk("partial_fe_width", fe_cycles - fe0, 1);
      chk("partial_no_word", hs_count - hs0, 0);
      cs_low();
      send_word(16'h8002);
      cs_high();
      chk("after_partial_hs", hs_count - hs0, 1);
    end

    // SCK toggling with nCS high is ignored
    hs0 = hs_count; fe0 = fe_cycles;
    send_bits(16'($urandom), 16);
    @(negedge clk);
    chk("cs_high_busy", 32'(busy), 0);
    #400;
    chk("cs_high_no_word", hs_count - hs0, 0);
    w = 16'($urandom);
    cs_low();
    send_word(w);
    cs_high();
    chk("cs_high_next_hs", hs_count - hs0, 1);
    chk("cs_high_no_fe", fe_cycles - fe0, 0);

    // Reset in the middle of a frame while nCS stays low
    hs0 = hs_count; fe0 = fe_cycles;
    w = 16'($urandom);
    cs_low();
    send_bits(w, 5);
    @(posedge clk);
    #5 nRST = 1'b0;
    repeat (2) @(posedge clk);
    #5 nRST = 1'b1;
    #200;
    chk("rst_mid_busy", 32'(busy), 0);
    for (int i = 10; i >= 0; i--) sck_bit(w[i]);
    cs_high();
    chk("rst_mid_no_word", hs_count - hs0, 0);
    chk("rst_mid_no_fe", fe_cycles - fe0, 0);
    cs_low();
    send_word(16'h0840);
    cs_high();
    chk("rst_mid_next_hs", hs_count - hs0, 1);

    // Random words with a randomly stalling consumer
    hs0 = hs_count;
    done = 1'b0;
    cs_low();
    fork
      begin
        for (int i = 0; i < 12; i++) send_word(16'($urandom));
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #5 word_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    cs_high();
    set_ready(1'b1);
    #400;
    chk("rand_hs", hs_count - hs0, 12);
    chk("rand_drained", model_q.size(), 0);
    chk("rand_overflow", 32'(overflow), 32'(model_ov));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
